// File: rtl/ivector_host_bridge.sv
// Host bridge: packs inbound words into say ValuePairs and
// unpacks heard ValuePairs into outbound words.
module ivector_host_bridge #(
  parameter int WORDW = 32,
  parameter int CNTW  = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               win__ENA,
  input  logic [WORDW-1:0]   win_v,
  output logic               win__RDY,
  output logic               say__ENA,
  output logic [3*WORDW-1:0] say_v,
  input  logic               say__RDY,
  input  logic               heard__ENA,
  input  logic [3*WORDW-1:0] heard_v,
  output logic               heard__RDY,
  output logic               wout__ENA,
  output logic [WORDW-1:0]   wout_v,
  input  logic               wout__RDY,
  output logic [CNTW-1:0]    say_count,
  output logic [CNTW-1:0]    heard_count
);

  logic [1:0]         asm_idx_q, asm_idx_d;
  logic [WORDW-1:0]   a_q, a_d;
  logic [WORDW-1:0]   b_q, b_d;
  logic [3*WORDW-1:0] pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [3*WORDW-1:0] out_buf_q, out_buf_d;
  logic [1:0]         out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d;
  logic [CNTW-1:0]    say_cnt_q, say_cnt_d;
  logic [CNTW-1:0]    heard_cnt_q, heard_cnt_d;

  logic win_fire, heard_fire;

  assign win__RDY   = (asm_idx_q != 2'd2) | ~pend_valid_q;
  assign heard__RDY = ~out_valid_q;
  assign say__ENA   = pend_valid_q & say__RDY;
  assign say_v      = pend_q;
  assign wout__ENA  = out_valid_q & wout__RDY;
  assign say_count   = say_cnt_q;
  assign heard_count = heard_cnt_q;

  assign win_fire   = win__ENA & win__RDY;
  assign heard_fire = heard__ENA & heard__RDY;

  always_comb begin
    case (out_idx_q)
      2'd0:    wout_v = out_buf_q[WORDW-1:0];
      2'd1:    wout_v = out_buf_q[2*WORDW-1:WORDW];
      default: wout_v = out_buf_q[3*WORDW-1:2*WORDW];
    endcase
  end

  always_comb begin
    asm_idx_d    = asm_idx_q;
    a_d          = a_q;
    b_d          = b_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    say_cnt_d    = say_cnt_q;
    if (say__ENA) begin
      pend_valid_d = 1'b0;
      say_cnt_d    = say_cnt_q + CNTW'(1);
    end
    if (win_fire) begin
      case (asm_idx_q)
        2'd0: a_d = win_v;
        2'd1: b_d = win_v;
        default: begin
          pend_d       = {win_v, b_q, a_q};
          pend_valid_d = 1'b1;
        end
      endcase
      asm_idx_d = (asm_idx_q == 2'd2) ? 2'd0 : asm_idx_q + 2'd1;
    end
  end

  always_comb begin
    out_buf_d   = out_buf_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    heard_cnt_d = heard_cnt_q;
    if (heard_fire) begin
      out_buf_d   = heard_v;
      out_idx_d   = 2'd0;
      out_valid_d = 1'b1;
      heard_cnt_d = heard_cnt_q + CNTW'(1);
    end else if (wout__ENA) begin
      if (out_idx_q == 2'd2) out_valid_d = 1'b0;
      else                   out_idx_d   = out_idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      asm_idx_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      out_buf_q    <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      say_cnt_q    <= '0;
      heard_cnt_q  <= '0;
    end else begin
      asm_idx_q    <= asm_idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_buf_q    <= out_buf_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
      say_cnt_q    <= say_cnt_d;
      heard_cnt_q  <= heard_cnt_d;
    end
  end

endmodule

// File: tb/tb_ivector_host_bridge.sv
// Directed bench for ivector_host_bridge, ending in an echo loopback.
// CNTW is shrunk to 8 so counter wrap is reachable quickly.
module tb_ivector_host_bridge;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam int NP = 300;

  logic          clk = 1'b0;
  logic          nrst;
  logic          win_ena;
  logic [W-1:0]  win_v;
  logic          win_rdy;
  logic          say_ena;
  logic [3*W-1:0] say_v;
  logic          say_rdy;
  logic          heard_ena;
  logic [3*W-1:0] heard_v;
  logic          heard_rdy;
  logic          wout_ena;
  logic [W-1:0]  wout_v;
  logic          wout_rdy;
  logic [CW-1:0] say_cnt;
  logic [CW-1:0] heard_cnt;

  logic           loop;
  wire            say_rdy_n   = loop ? heard_rdy : say_rdy;
  wire            heard_ena_n = loop ? say_ena : heard_ena;
  wire [3*W-1:0]  heard_v_n   = loop ? say_v : heard_v;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] data [NP*3];
  logic [W-1:0] exp_w [3];

  always #5 clk = ~clk;

  ivector_host_bridge #(.WORDW(W), .CNTW(CW)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .win__ENA    (win_ena),
    .win_v       (win_v),
    .win__RDY    (win_rdy),
    .say__ENA    (say_ena),
    .say_v       (say_v),
    .say__RDY    (say_rdy_n),
    .heard__ENA  (heard_ena_n),
    .heard_v     (heard_v_n),
    .heard__RDY  (heard_rdy),
    .wout__ENA   (wout_ena),
    .wout_v      (wout_v),
    .wout__RDY   (wout_rdy),
    .say_count   (say_cnt),
    .heard_count (heard_cnt)
  );

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; loop = 1'b0;
    win_ena = 1'b0; win_v = '0;
    say_rdy = 1'b1; heard_ena = 1'b0; heard_v = '0;
    wout_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_win_rdy", 96'(win_rdy), 96'd1);
    chk("rst_heard_rdy", 96'(heard_rdy), 96'd1);
    chk("rst_say_ena", 96'(say_ena), 96'd0);
    chk("rst_wout_ena", 96'(wout_ena), 96'd0);
    chk("rst_say_v", 96'(say_v), 96'd0);
    chk("rst_wout_v", 96'(wout_v), 96'd0);
    chk("rst_say_cnt", 96'(say_cnt), 96'd0);
    chk("rst_heard_cnt", 96'(heard_cnt), 96'd0);
    nrst = 1'b1;

    @(negedge clk); win_ena = 1'b1; win_v = 32'h11;
    @(negedge clk); win_v = 32'h22;
    @(negedge clk); win_v = 32'h33;
    @(negedge clk); win_ena = 1'b0;
    chk("p1_say_ena", 96'(say_ena), 96'd1);
    chk("p1_say_v", say_v, 96'h00000033_00000022_00000011);
    @(negedge clk);
    chk("p1_say_ena_off", 96'(say_ena), 96'd0);
    chk("p1_say_cnt", 96'(say_cnt), 96'd1);

    say_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("bp_win_rdy", 96'(win_rdy), 96'd1);
      win_ena = 1'b1; win_v = 32'(i);
    end
    @(negedge clk); win_ena = 1'b0;
    chk("bp_win_stall", 96'(win_rdy), 96'd0);
    chk("bp_say_ena", 96'(say_ena), 96'd0);
    chk("bp_pend_hold", say_v, {32'd3, 32'd2, 32'd1});
    @(negedge clk);
    chk("bp_pend_hold2", say_v, {32'd3, 32'd2, 32'd1});
    say_rdy = 1'b1; #1;
    chk("bp_say1_ena", 96'(say_ena), 96'd1);
    chk("bp_say1_v", say_v, {32'd3, 32'd2, 32'd1});
    @(negedge clk);
    chk("bp_win_rdy_back", 96'(win_rdy), 96'd1);
    chk("bp_say_ena_gap", 96'(say_ena), 96'd0);
    win_ena = 1'b1; win_v = 32'd6;
    @(negedge clk); win_ena = 1'b0;
    chk("bp_say2_ena", 96'(say_ena), 96'd1);
    chk("bp_say2_v", say_v, {32'd6, 32'd5, 32'd4});
    @(negedge clk);
    chk("bp_say_cnt", 96'(say_cnt), 96'd3);

    @(negedge clk);
    chk("h_rdy_idle", 96'(heard_rdy), 96'd1);
    heard_ena = 1'b1; heard_v = 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA;
    @(negedge clk); heard_ena = 1'b0;
    chk("h_w0_ena", 96'(wout_ena), 96'd1);
    chk("h_w0", 96'(wout_v), 96'hAAAAAAAA);
    chk("h_rdy0", 96'(heard_rdy), 96'd0);
    @(negedge clk);
    chk("h_w1", 96'(wout_v), 96'hBBBBBBBB);
    chk("h_rdy1", 96'(heard_rdy), 96'd0);
    @(negedge clk);
    chk("h_w2", 96'(wout_v), 96'hCCCCCCCC);
    chk("h_rdy2", 96'(heard_rdy), 96'd0);
    @(negedge clk);
    chk("h_rdy_back", 96'(heard_rdy), 96'd1);
    chk("h_wout_off", 96'(wout_ena), 96'd0);
    chk("h_cnt", 96'(heard_cnt), 96'd1);

    exp_w[0] = 32'h1234_0001;
    exp_w[1] = 32'h5678_0002;
    exp_w[2] = 32'h9ABC_0003;
    @(negedge clk);
    heard_ena = 1'b1; heard_v = {exp_w[2], exp_w[1], exp_w[0]};
    wout_rdy = 1'b0;
    begin
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      @(negedge clk); heard_ena = 1'b0;
      while (k < 3 && cyc < 200) begin
        chk("st_heard_rdy", 96'(heard_rdy), 96'd0);
        wout_rdy = ($urandom_range(0, 2) == 0);
        #1;
        chk("st_word", 96'(wout_v), 96'(exp_w[k]));
        chk("st_ena", 96'(wout_ena), 96'(wout_rdy));
        if (wout_ena) k++;
        @(negedge clk);
        cyc++;
      end
      chk("st_all_out", 96'(k), 96'd3);
      chk("st_heard_rdy_back", 96'(heard_rdy), 96'd1);
      chk("st_cnt", 96'(heard_cnt), 96'd2);
    end

    wout_rdy = 1'b0;
    win_ena = 1'b1; win_v = 32'h77;
    heard_ena = 1'b1; heard_v = 96'h1;
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    win_ena = 1'b0; heard_ena = 1'b0;
    chk("ar_win_rdy", 96'(win_rdy), 96'd1);
    chk("ar_heard_rdy", 96'(heard_rdy), 96'd1);
    chk("ar_say_ena", 96'(say_ena), 96'd0);
    chk("ar_say_v", 96'(say_v), 96'd0);
    chk("ar_wout_v", 96'(wout_v), 96'd0);
    chk("ar_say_cnt", 96'(say_cnt), 96'd0);
    chk("ar_heard_cnt", 96'(heard_cnt), 96'd0);
    @(negedge clk); nrst = 1'b1;

    for (int i = 0; i < NP * 3; i++) data[i] = $urandom;
    loop = 1'b1;
    begin
      int fi;
      int oi;
      fi = 0;
      oi = 0;
      for (int cyc = 0; cyc < 8000 && oi < NP * 3; cyc++) begin
        @(negedge clk);
        wout_rdy = ($urandom_range(0, 3) != 0);
        if (win_rdy && fi < NP * 3) begin
          win_ena = 1'b1; win_v = data[fi]; fi++;
        end else begin
          win_ena = 1'b0;
        end
        #1;
        if (wout_ena) begin
          chk("loop_word", 96'(wout_v), 96'(data[oi]));
          oi++;
        end
      end
      win_ena = 1'b0;
      chk("loop_count", 96'(oi), 96'(NP * 3));
      @(negedge clk);
      chk("loop_say_cnt", 96'(say_cnt), 96'(NP % 256));
      chk("loop_heard_cnt", 96'(heard_cnt), 96'(NP % 256));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
